// File: rtl/conv_param_bank.sv
// Double-buffered, runtime-loadable weight/bias store for one conv2d layer.
// A streamed set fills the shadow bank; it is promoted to the active bank only at an image boundary.
module conv_param_bank #(
  parameter int unsigned OUTPUT_CHANNELS = 4,
  parameter int unsigned INPUT_CHANNELS  = 1,
  parameter int unsigned KERNAL_SIZE     = 3,
  parameter int unsigned WEIGHT_BITS     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [WEIGHT_BITS-1:0] ld_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic                          ld_last,
  input  logic                          mon_valid,
  input  logic                          mon_ready,
  input  logic                          mon_last,
  output logic signed [WEIGHT_BITS-1:0] o_weights [OUTPUT_CHANNELS][INPUT_CHANNELS][KERNAL_SIZE][KERNAL_SIZE],
  output logic signed [WEIGHT_BITS-1:0] o_bias [OUTPUT_CHANNELS],
  output logic                          o_params_valid,
  output logic                          o_swap,
  output logic                          o_load_err
);

  localparam int unsigned KK    = KERNAL_SIZE * KERNAL_SIZE;
  localparam int unsigned NW    = OUTPUT_CHANNELS * INPUT_CHANNELS * KK;
  localparam int unsigned TOTAL = NW + OUTPUT_CHANNELS;
  localparam int unsigned CW    = $clog2(TOTAL);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_DRAIN   = 2'd1,
    S_PENDING = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt;
  logic                     frame_open;
  logic signed [WEIGHT_BITS-1:0] shadow [TOTAL];

  logic mon_acc;
  logic at_end;
  logic shadow_we, cnt_inc, cnt_clr, err_c, commit;

  assign mon_acc = mon_valid & mon_ready;
  assign at_end  = (cnt == CW'(TOTAL - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  // Next-state logic; ld_ready is 1 in LOAD/DRAIN so ld_valid alone means an accepted beat there
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_LOAD:    if (ld_valid && at_end) state_nxt = ld_last ? S_PENDING : S_DRAIN;
      S_DRAIN:   if (ld_valid && ld_last) state_nxt = S_LOAD;
      S_PENDING: if (commit) state_nxt = S_LOAD;
      default:   state_nxt = S_LOAD;
    endcase
  end

  // Output/control decode
  always_comb begin
    ld_ready  = 1'b0;
    shadow_we = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    err_c     = 1'b0;
    commit    = 1'b0;
    unique case (state)
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          if (at_end) begin
            shadow_we = ld_last;
          end else if (ld_last) begin
            err_c   = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            shadow_we = 1'b1;
            cnt_inc   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) begin
          err_c   = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      S_PENDING: begin
        // A mon beat that opens a frame blocks the commit; the closing beat enables it
        commit  = (!frame_open && !mon_acc) || (mon_acc && mon_last);
        cnt_clr = commit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      frame_open     <= 1'b0;
      o_swap         <= 1'b0;
      o_load_err     <= 1'b0;
      o_params_valid <= 1'b0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);
      if (mon_acc) frame_open <= !mon_last;
      o_swap     <= commit;
      o_load_err <= err_c;
      if (commit) o_params_valid <= 1'b1;
    end
  end

  // Shadow bank fill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < TOTAL; k++) shadow[k] <= '0;
    end else if (shadow_we) begin
      shadow[cnt] <= ld_data;
    end
  end

  // Active bank, replaced wholesale on commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned o = 0; o < OUTPUT_CHANNELS; o++) begin
        o_bias[o] <= '0;
        for (int unsigned i = 0; i < INPUT_CHANNELS; i++)
          for (int unsigned r = 0; r < KERNAL_SIZE; r++)
            for (int unsigned c = 0; c < KERNAL_SIZE; c++)
              o_weights[o][i][r][c] <= '0;
      end
    end else if (commit) begin
      for (int unsigned o = 0; o < OUTPUT_CHANNELS; o++) begin
        o_bias[o] <= shadow[NW + o];
        for (int unsigned i = 0; i < INPUT_CHANNELS; i++)
          for (int unsigned r = 0; r < KERNAL_SIZE; r++)
            for (int unsigned c = 0; c < KERNAL_SIZE; c++)
              o_weights[o][i][r][c] <= shadow[o*INPUT_CHANNELS*KK + i*KK + r*KERNAL_SIZE + c];
      end
    end
  end

endmodule

// File: tb/tb_conv_param_bank.sv
// Bench for conv_param_bank: table of load scenarios plus hand-built frame/reset sequences.
// Expected banks are queued when a load is driven and compared when o_swap appears.
module tb_conv_param_bank;

  localparam int OC = 4, IC = 1, K = 3, W = 32;
  localparam int KK = K * K, NW = OC * IC * KK, TOTAL = NW + OC;

  typedef logic [TOTAL*W-1:0] set_t;

  typedef struct {
    int nbeats;
    int last_at;
    int base;
    int step;
    bit rnd;
    bit exp_swap;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic signed [W-1:0] ld_data;
  logic ld_valid, ld_ready, ld_last;
  logic mon_valid, mon_ready, mon_last;
  logic signed [W-1:0] o_weights [OC][IC][K][K];
  logic signed [W-1:0] o_bias [OC];
  logic o_params_valid, o_swap, o_load_err;

  conv_param_bank #(
    .OUTPUT_CHANNELS(OC), .INPUT_CHANNELS(IC), .KERNAL_SIZE(K), .WEIGHT_BITS(W)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_last(ld_last),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
    .o_weights(o_weights), .o_bias(o_bias),
    .o_params_valid(o_params_valid), .o_swap(o_swap), .o_load_err(o_load_err)
  );

  always #5 clk = ~clk;

  int   checks = 0, failures = 0;
  int   swap_cnt = 0, err_cnt = 0;
  set_t exp_q[$];
  set_t model_act = '0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [W-1:0] act_val(input int k);
    int o, i, r, c;
    if (k < NW) begin
      o = k / (IC * KK);
      i = (k / KK) % IC;
      r = (k % KK) / K;
      c = k % K;
      return o_weights[o][i][r][c];
    end
    return o_bias[k - NW];
  endfunction

  task automatic compare_bank(input string name, input set_t e);
    int nbad = 0;
    logic signed [W-1:0] ev;
    for (int k = 0; k < TOTAL; k++) begin
      ev = e[k*W +: W];
      if (act_val(k) !== ev) nbad++;
    end
    check(name, nbad, 0);
  endtask

  // Scoreboard: every swap must match the oldest queued set
  set_t popped;
  always @(negedge clk) begin
    if (!reset) begin
      if (o_load_err) err_cnt++;
      if (o_swap) begin
        swap_cnt++;
        check("swap_has_expectation", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          popped = exp_q.pop_front();
          compare_bank("swap_bank", popped);
          check("params_valid_on_swap", o_params_valid, 1);
          model_act = popped;
        end
      end
    end
  end

  task automatic send_load(input int n, input int last_at, input int base, input int step,
                           input bit rnd, output set_t s);
    int g;
    s = '0;
    for (int k = 0; k < n; k++) begin
      if (rnd) begin
        ld_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      ld_data  = W'(base + k * step);
      ld_valid = 1'b1;
      ld_last  = (k + 1 == last_at);
      g = 0;
      while (!ld_ready && g < 200) begin @(posedge clk); #1; g++; end
      if (!ld_ready) check("ld_ready_timeout", ld_ready, 1);
      @(posedge clk); #1;
      if (k < TOTAL) s[k*W +: W] = W'(base + k * step);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic mon_beat(input bit last, input bit rnd_ready);
    bit acc;
    int g = 0;
    mon_valid = 1'b1;
    mon_last  = last;
    do begin
      mon_ready = rnd_ready && g < 10 ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = mon_ready;
      @(posedge clk); #1;
      g++;
    end while (!acc);
    mon_valid = 1'b0;
    mon_ready = 1'b0;
    mon_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  vec_t vecs[5];
  set_t s;
  int   sw0, er0;

  initial begin
    reset = 1'b1;
    ld_data = '0; ld_valid = 1'b0; ld_last = 1'b0;
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    vecs[0] = '{40, 40, 1, 1, 1'b0, 1'b1};
    vecs[1] = '{20, 20, 500, 1, 1'b0, 1'b0};
    vecs[2] = '{40, 40, 100, 3, 1'b1, 1'b1};
    vecs[3] = '{45, 45, 900, 1, 1'b0, 1'b0};
    vecs[4] = '{40, 40, -1000, -7, 1'b0, 1'b1};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_ld_ready", ld_ready, 1);
    check("reset_params_valid", o_params_valid, 0);
    check("reset_swap", o_swap, 0);
    check("reset_load_err", o_load_err, 0);
    compare_bank("reset_bank", '0);

    // Table-driven load scenarios with an idle monitor
    foreach (vecs[i]) begin
      sw0 = swap_cnt; er0 = err_cnt;
      send_load(vecs[i].nbeats, vecs[i].last_at, vecs[i].base, vecs[i].step, vecs[i].rnd, s);
      if (vecs[i].exp_swap) begin
        exp_q.push_back(s);
        check("pending_ld_ready", ld_ready, 0);
        check("swap_not_early", o_swap, 0);
        @(posedge clk); #1;
        check("swap_latency", o_swap, 1);
        repeat (2) @(posedge clk); #1;
        check("swap_count", swap_cnt - sw0, 1);
        check("no_err_on_good_load", err_cnt - er0, 0);
        check("ld_ready_after_commit", ld_ready, 1);
      end else begin
        check("err_pulse_timing", o_load_err, 1);
        repeat (3) @(posedge clk); #1;
        check("err_count", err_cnt - er0, 1);
        check("no_swap_on_bad_load", swap_cnt - sw0, 0);
        compare_bank("bank_unchanged_after_err", model_act);
        check("ld_ready_after_err", ld_ready, 1);
      end
      if (i == 0) begin
        check("w0000", o_weights[0][0][0][0], 1);
        check("w3022", o_weights[3][0][2][2], 36);
        check("bias0", o_bias[0], 37);
        check("bias3", o_bias[3], 40);
        check("params_valid", o_params_valid, 1);
      end
    end

    // Mid-frame hold: commit waits for the frame's closing beat
    mon_beat(1'b0, 1'b0);
    sw0 = swap_cnt;
    send_load(40, 40, -5, 0, 1'b0, s);
    exp_q.push_back(s);
    repeat (6) begin
      check("hold_ld_ready", ld_ready, 0);
      check("hold_no_swap", o_swap, 0);
      @(posedge clk); #1;
    end
    compare_bank("hold_old_bank", model_act);
    mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
    compare_bank("last_beat_old_bank", model_act);
    @(posedge clk); #1;
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    check("hold_swap_at_t1", o_swap, 1);
    check("hold_w2011", o_weights[2][0][1][1], -5);
    check("hold_bias1", o_bias[1], -5);
    repeat (2) @(posedge clk); #1;
    check("hold_swap_count", swap_cnt - sw0, 1);

    // Backpressure: random load gaps, frame opened on the first PENDING cycle
    sw0 = swap_cnt;
    send_load(40, 40, 7, 11, 1'b1, s);
    exp_q.push_back(s);
    mon_beat(1'b0, 1'b0);
    check("bp_no_commit_on_open", o_swap, 0);
    repeat (8) begin @(posedge clk); #1; end
    check("bp_ld_ready_blocked", ld_ready, 0);
    for (int b = 0; b < 3; b++) mon_beat(1'b0, 1'b1);
    check("bp_no_swap_before_last", swap_cnt - sw0, 0);
    mon_beat(1'b1, 1'b1);
    check("bp_swap_after_last", o_swap, 1);
    repeat (4) @(posedge clk); #1;
    check("bp_exactly_one_swap", swap_cnt - sw0, 1);

    // Single-beat frame on the first PENDING cycle is a commit point
    sw0 = swap_cnt;
    send_load(40, 40, 3, -2, 1'b0, s);
    exp_q.push_back(s);
    mon_beat(1'b1, 1'b0);
    check("single_beat_swap", o_swap, 1);
    repeat (2) @(posedge clk); #1;
    check("single_beat_count", swap_cnt - sw0, 1);

    // Reset in the middle of a load
    sw0 = swap_cnt;
    send_load(25, 0, 50, 1, 1'b0, s);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_act = '0;
    check("mid_reset_params_valid", o_params_valid, 0);
    check("mid_reset_ld_ready", ld_ready, 1);
    compare_bank("mid_reset_bank", '0);
    send_load(40, 40, 20, 1, 1'b0, s);
    exp_q.push_back(s);
    repeat (3) @(posedge clk); #1;
    check("post_reset_swap", swap_cnt - sw0, 1);
    check("post_reset_w0", o_weights[0][0][0][0], 20);
    check("post_reset_bias0", o_bias[0], 56);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
